// File: rtl/buffer_512_to_64_ctrl_if.sv
// Control/handshake bundle for the 512-to-64 buffer job sequencer.
// master = environment side (job issuer, upstream, buffer status, downstream),
// slave  = the sequencer itself.
interface buffer_512_to_64_ctrl_if #(
    parameter int LINE_CNT_W = 16
);
    // job control
    logic                  start;
    logic [LINE_CNT_W-1:0] num_lines;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    // upstream 512-bit stream
    logic                  in_valid;
    logic                  in_ready;
    // buffer control/status
    logic                  buf_clr;
    logic                  buf_wr_enable;
    logic                  buf_rd_enable;
    logic                  buf_full;
    logic                  buf_empty;
    // downstream 64-bit stream
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output start, num_lines, abort, in_valid, buf_full, buf_empty, out_ready,
        input  busy, done, aborted, in_ready, buf_clr, buf_wr_enable,
               buf_rd_enable, out_valid, out_last
    );

    modport slave (
        input  start, num_lines, abort, in_valid, buf_full, buf_empty, out_ready,
        output busy, done, aborted, in_ready, buf_clr, buf_wr_enable,
               buf_rd_enable, out_valid, out_last
    );
endinterface

// File: rtl/buffer_512_to_64_ctrl.sv
// Job sequencer for the 512-to-64 width-conversion buffer.
// Clears the buffer, gates N upstream lines in and 8*N words out, flags the
// last word and reports done/aborted. Data buses bypass this block.
module buffer_512_to_64_ctrl #(
    parameter int LINE_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    buffer_512_to_64_ctrl_if.slave   bus
);
    localparam int WCW = LINE_CNT_W + 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t                state;
    logic [LINE_CNT_W-1:0] len_q;
    logic [LINE_CNT_W-1:0] lines_in;
    logic [WCW-1:0]        words_out;

    logic           run;
    logic [WCW-1:0] last_idx;
    logic           in_rdy;
    logic           wr;
    logic           out_vld;
    logic           rd;
    logic           last;

    // Index of the final word; 3 extra bits keep len_q*8-1 from overflowing.
    assign last_idx = {len_q, 3'b000} - WCW'(1);

    // Handshake gating, only live in RUN; no path from in_valid to out_valid.
    assign run     = (state == S_RUN);
    assign in_rdy  = run & ~bus.buf_full & (lines_in < len_q);
    assign wr      = bus.in_valid & in_rdy;
    assign out_vld = run & ~bus.buf_empty;
    assign rd      = out_vld & bus.out_ready;
    assign last    = out_vld & (words_out == last_idx);

    assign bus.in_ready      = in_rdy;
    assign bus.buf_wr_enable = wr;
    assign bus.out_valid     = out_vld;
    assign bus.buf_rd_enable = rd;
    assign bus.out_last      = last;

    // Status strobes are pure decodes of the state register.
    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_DONE);
    assign bus.aborted = (state == S_ABORT);
    assign bus.buf_clr = (state == S_CLEAR) | (state == S_ABORT);

    // Job FSM with line/word counters; abort wins over the last pop but that pop still counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            lines_in  <= '0;
            words_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q     <= bus.num_lines;
                        lines_in  <= '0;
                        words_out <= '0;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (bus.abort)
                        state <= S_ABORT;
                    else if (len_q == '0)
                        state <= S_DONE;
                    else
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (wr)
                        lines_in <= lines_in + LINE_CNT_W'(1);
                    if (rd)
                        words_out <= words_out + WCW'(1);
                    if (bus.abort)
                        state <= S_ABORT;
                    else if (rd && last)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                S_ABORT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_buffer_512_to_64_ctrl.sv
// Directed bench for buffer_512_to_64_ctrl with a small 2-line buffer model.
module tb_buffer_512_to_64_ctrl;
    localparam int LW  = 16;
    localparam int CAP = 16;   // buffer model capacity in 64-bit words

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    buffer_512_to_64_ctrl_if #(.LINE_CNT_W(LW)) bus ();

    buffer_512_to_64_ctrl #(.LINE_CNT_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // buffer model and per-job observations
    logic [63:0] q[$];
    int up_idx, exp_word, lines_acc;
    int r_wr, r_rd, r_last, r_last_word, r_last_cyc, r_done_n, r_done_cyc;
    int r_ab_n, r_ab_cyc, r_clr_n, r_clr_cyc, r_first_wr, r_first_ov;
    int r_ir_bad, r_ir_n, r_ov_n, r_busy_end, r_full_seen, r_ord_bad, r_rst_bad;

    task automatic set_flags();
        bus.buf_empty = (q.size() == 0);
        bus.buf_full  = (q.size() > CAP - 8);
    endtask

    // Runs one job from a negedge with the DUT idle. cycle 0 = start accept edge.
    task automatic run_job(input int nl, input int offered, input bit hold,
                           input int abort_at, input int bstart_cyc, input int rst_cyc);
        bit released, finished;
        int end_cyc;
        logic [63:0] w;
        r_wr = 0; r_rd = 0; r_last = 0; r_last_word = -1; r_last_cyc = -1;
        r_done_n = 0; r_done_cyc = -1; r_ab_n = 0; r_ab_cyc = -1; r_clr_n = 0;
        r_clr_cyc = -1; r_first_wr = -1; r_first_ov = -1; r_ir_bad = 0; r_ir_n = 0;
        r_ov_n = 0; r_busy_end = -1; r_full_seen = 0; r_ord_bad = 0; r_rst_bad = 0;
        up_idx = 0; exp_word = 1; lines_acc = 0;
        released = !hold; finished = 0; end_cyc = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.start     = (cyc == 0) || (cyc == bstart_cyc);
            bus.num_lines = (cyc == 0) ? LW'(nl) : LW'(nl + 7);
            set_flags();
            if (bus.buf_full) begin
                released    = 1;
                r_full_seen = 1;
            end
            bus.out_ready = released;
            bus.in_valid  = (up_idx < offered);
            bus.abort     = (abort_at >= 0) && (r_rd == abort_at);
            rst           = (cyc == rst_cyc) ? 1'b0 : 1'b1;
            #1;
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
                r_rst_bad = bus.busy + bus.done + bus.aborted + bus.in_ready + bus.buf_clr
                          + bus.buf_wr_enable + bus.buf_rd_enable + bus.out_valid + bus.out_last;
                finished = 1;
                break;
            end
            if (end_cyc >= 0 && cyc == end_cyc) begin
                r_busy_end = bus.busy;
                finished   = 1;
                break;
            end
            if (bus.in_ready && (lines_acc >= nl || bus.buf_full)) r_ir_bad++;
            if (bus.in_ready) r_ir_n++;
            if (bus.out_valid) begin
                r_ov_n++;
                if (r_first_ov < 0) r_first_ov = cyc;
            end
            if (bus.buf_wr_enable && r_first_wr < 0) r_first_wr = cyc;
            if (bus.buf_clr) begin
                r_clr_n++;
                if (r_clr_cyc < 0) r_clr_cyc = cyc;
            end
            if (bus.out_last) begin
                r_last++;
                r_last_word = (q.size() > 0) ? int'(q[0]) : -1;
                r_last_cyc  = cyc;
            end
            if (bus.done) begin
                r_done_n++;
                r_done_cyc = cyc;
                end_cyc    = cyc + 1;
            end
            if (bus.aborted) begin
                r_ab_n++;
                r_ab_cyc = cyc;
                end_cyc  = cyc + 1;
            end
            @(posedge clk);
            if (bus.buf_clr) q.delete();
            if (bus.buf_rd_enable) begin
                r_rd++;
                if (q.size() == 0) r_ord_bad++;
                else begin
                    w = q.pop_front();
                    if (w != 64'(exp_word)) r_ord_bad++;
                end
                exp_word++;
            end
            if (bus.buf_wr_enable) begin
                r_wr++;
                for (int k = 1; k <= 8; k++) q.push_back(64'(8 * up_idx + k));
                up_idx++;
                lines_acc++;
            end
            @(negedge clk);
        end
        if (!finished) chk("job_timeout", 1, 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.start = 0; bus.num_lines = '0; bus.abort = 0; bus.in_valid = 0;
        bus.out_ready = 0; bus.buf_full = 0; bus.buf_empty = 1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done_abort", {bus.done, bus.aborted}, 0);
        chk("rst_handshake", {bus.in_ready, bus.out_valid, bus.out_last}, 0);
        chk("rst_buf_ctl", {bus.buf_clr, bus.buf_wr_enable, bus.buf_rd_enable}, 0);
        rst = 1'b1;
        @(negedge clk);

        // 3 lines, free-running downstream
        run_job(3, 3, 0, -1, -1, -1);
        chk("t1_clr_cyc", r_clr_cyc, 1);
        chk("t1_clr_n", r_clr_n, 1);
        chk("t1_first_wr", r_first_wr, 2);
        chk("t1_first_ov", r_first_ov, 3);
        chk("t1_wr", r_wr, 3);
        chk("t1_rd", r_rd, 24);
        chk("t1_order", r_ord_bad, 0);
        chk("t1_last_n", r_last, 1);
        chk("t1_last_word", r_last_word, 24);
        chk("t1_last_cyc", r_last_cyc, 26);
        chk("t1_done_cyc", r_done_cyc, 27);
        chk("t1_done_n", r_done_n, 1);
        chk("t1_busy_end", r_busy_end, 0);
        chk("t1_aborted", r_ab_n, 0);

        // downstream held until buffer fills
        run_job(3, 3, 1, -1, -1, -1);
        chk("t2_full_seen", r_full_seen, 1);
        chk("t2_ir_bad", r_ir_bad, 0);
        chk("t2_wr", r_wr, 3);
        chk("t2_rd", r_rd, 24);
        chk("t2_order", r_ord_bad, 0);
        chk("t2_last_word", r_last_word, 24);
        chk("t2_done_n", r_done_n, 1);

        // empty job
        run_job(0, 3, 0, -1, -1, -1);
        chk("t3_clr_cyc", r_clr_cyc, 1);
        chk("t3_done_cyc", r_done_cyc, 2);
        chk("t3_ir_n", r_ir_n, 0);
        chk("t3_ov_n", r_ov_n, 0);
        chk("t3_wr", r_wr, 0);
        chk("t3_busy_end", r_busy_end, 0);

        // 2 lines with 5 offered, plus a start pulse while busy
        run_job(2, 5, 0, -1, 6, -1);
        chk("t4_wr", r_wr, 2);
        chk("t4_ir_bad", r_ir_bad, 0);
        chk("t4_rd", r_rd, 16);
        chk("t4_order", r_ord_bad, 0);
        chk("t4_last_n", r_last, 1);
        chk("t4_last_word", r_last_word, 16);
        chk("t4_done_n", r_done_n, 1);

        // abort after 5 words; abort cycle still pops word 6
        run_job(3, 3, 0, 5, -1, -1);
        chk("t5_rd", r_rd, 6);
        chk("t5_order", r_ord_bad, 0);
        chk("t5_ab_n", r_ab_n, 1);
        chk("t5_ab_cyc", r_ab_cyc, 9);
        chk("t5_clr_n", r_clr_n, 2);
        chk("t5_done_n", r_done_n, 0);
        chk("t5_busy_end", r_busy_end, 0);

        // full job after the abort
        run_job(3, 3, 0, -1, -1, -1);
        chk("t6_rd", r_rd, 24);
        chk("t6_order", r_ord_bad, 0);
        chk("t6_last_word", r_last_word, 24);
        chk("t6_done_n", r_done_n, 1);

        // reset mid-RUN, then a 1-line job
        run_job(3, 3, 0, -1, -1, 6);
        chk("t7_rst_outputs", r_rst_bad, 0);
        chk("t7_done_n", r_done_n, 0);
        chk("t7_ab_n", r_ab_n, 0);
        chk("t7_clr_n", r_clr_n, 1);
        run_job(1, 1, 0, -1, -1, -1);
        chk("t8_rd", r_rd, 8);
        chk("t8_order", r_ord_bad, 0);
        chk("t8_last_word", r_last_word, 8);
        chk("t8_done_n", r_done_n, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
